apb4_pwm_cap: RTL and testbench
===============================

APB4_PWM_CAP -- requirements
Module: apb4_pwm_cap

Interface
REQ-001 SHALL have parameter SYNC_STAGE, default 2, setting the input synchronizer depth (2..3).
REQ-002 SHALL have one clock and reset: apb4_pclk input 1, the clock; reset is asynchronous and active-low.
REQ-003 apb4_presetn  input  1  asynchronous active-low reset.
REQ-004 apb4_paddr  input  32  byte address; register index = paddr[5:2].
REQ-005 apb4_pprot input 3 and apb4_pstrb input 4 are accepted and ignored.
REQ-006 apb4_psel / apb4_penable / apb4_pwrite  input  1 each  APB4 control.
REQ-007 apb4_pwdata input 32 write data; apb4_prdata output 32 read data.
REQ-008 apb4_pready output 1, tied 1; apb4_pslverr output 1, tied 0.
REQ-009 pwm_in_i  input  1  asynchronous PWM waveform to measure.
REQ-010 pwm_irq_o  output  1  interrupt = STAT.CAPIF | STAT.OVIF.

Function
REQ-011 Write strobe = psel&penable&pwrite; read strobe = psel&penable&~pwrite; prdata is combinational, zero outside a read strobe or on an unmapped index.
REQ-012 Map (index): CTRL 0 {[0]CAPIE,[1]EN,[2]OVIE,[3]POL} RW; PSCR 1 (16b) RW; PER 2 (32b) RO; HIGH 3 (32b) RO; STAT 4 {[0]CAPIF,[1]OVIF} RO clear-on-read; writes to RO indices are ignored.
REQ-013 pwm_in_i passes a SYNC_STAGE flop synchronizer, then is XORed with CTRL.POL; rising/falling edges come from a one-flop delayed copy, giving a fixed latency of SYNC_STAGE+1 cycles.
REQ-014 FSM IDLE/ARM/MEAS: EN=0 forces IDLE from any state and clears cnt/prescaler; IDLE->ARM when EN=1; ARM->MEAS on first rising edge, with no capture; falling edges in ARM are ignored.
REQ-015 On each rising edge: prescaler <= 0, cnt <= 1; tick = prescaler==PSCR (prescaler then wraps to 0); cnt increments by 1 on each tick.
REQ-016 Measured value after k cycles = 1 + floor((k-1)/(PSCR+1)); with PSCR=0 it is exact in cycles.
REQ-017 Rising edge in MEAS: PER <= cnt, and CAPIF set if CAPIE; falling edge in MEAS: HIGH <= cnt, with no flag.
REQ-018 cnt saturates at 32'hFFFF_FFFF: OVIF set if OVIE, state -> ARM, and the next rising edge performs no capture.
REQ-019 A PSCR write clears prescaler and cnt and forces MEAS -> ARM.
REQ-020 STAT read clears the flags being read; a set event in the same cycle wins and the flag stays 1.
REQ-021 PER/HIGH hold their last value when EN drops and are not cleared on enable.

Reset
REQ-022 On apb4_presetn=0: all registers, cnt and prescaler 0, synchronizer flops 0, FSM IDLE, pwm_irq_o=0, prdata=0.
REQ-023 Reset asserted mid-measurement aborts immediately; the first rising edge after release with EN=1 only arms.

Structure
REQ-024 Shared package/define file holds register indices, field widths (CTRL 4, PSCR 16, CNT 32, STAT 2), CTRL/STAT bit positions, and the FSM state enum.
REQ-025 One sub-module: the existing cdc_sync instance for pwm_in_i (STAGE=SYNC_STAGE, DATA_WIDTH=1); register flops use the existing dffer primitive.

Verification
REQ-026 PSCR=0, EN=1, CAPIE=1; input 3 high / 7 low repeating -> after second rising edge PER=10, HIGH=3, irq=1; STAT read returns 1 and irq drops.
REQ-027 PSCR=1, same waveform -> PER=5, HIGH=2.
REQ-028 POL=1, input 7 high / 3 low -> HIGH=3, PER=10.
REQ-029 OVIE=1, input held low after arming (force saturation via small CNT define in test build) -> OVIF=1; next rising edge leaves PER unchanged; the following edge captures.
REQ-030 STAT read in the same cycle as a rising-edge capture -> CAPIF remains 1; EN cleared mid-period -> no further captures and PER unchanged.
REQ-031 Reset pulse mid-period -> all reads 0; re-enable, first rising edge gives no capture and the second captures correctly.

Source files
------------

// File: rtl/apb4_pwm_cap_pkg.sv
// Shared definitions for the APB4 PWM capture block: register map,
// field widths and positions, and the measurement state encoding.
package apb4_pwm_cap_pkg;

  localparam logic [3:0] IDX_CTRL = 4'd0;
  localparam logic [3:0] IDX_PSCR = 4'd1;
  localparam logic [3:0] IDX_PER  = 4'd2;
  localparam logic [3:0] IDX_HIGH = 4'd3;
  localparam logic [3:0] IDX_STAT = 4'd4;

  localparam int CTRL_W = 4;
  localparam int PSCR_W = 16;
  localparam int CNT_W  = 32;
  localparam int STAT_W = 2;

  localparam int CTRL_CAPIE = 0;
  localparam int CTRL_EN    = 1;
  localparam int CTRL_OVIE  = 2;
  localparam int CTRL_POL   = 3;

  localparam int STAT_CAPIF = 0;
  localparam int STAT_OVIF  = 1;

  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_MEAS = 2'd2
  } meas_state_t;

endpackage

// File: rtl/cdc_sync.sv
// Multi-flop synchronizer for asynchronous inputs; STAGE flops deep,
// cleared by the asynchronous reset.
module cdc_sync #(
  parameter int STAGE      = 2,
  parameter int DATA_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  logic [STAGE-1:0][DATA_WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGE-2:0], d};
    end
  end

  assign q = sync_q[STAGE-1];

endmodule

// File: rtl/dffer.sv
// D flip-flop with load enable and asynchronous active-low clear.
module dffer #(
  parameter int DATA_W = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/apb4_pwm_cap.sv
// APB4 slave measuring period and high time of an asynchronous PWM input
// with a prescaled counter, capture/overflow flags and an interrupt.
module apb4_pwm_cap
  import apb4_pwm_cap_pkg::*;
#(
  parameter int               SYNC_STAGE = 2,
  parameter logic [CNT_W-1:0] CNT_MAX    = CNT_SAT
) (
  input  logic        apb4_pclk,
  input  logic        apb4_presetn,
  input  logic [31:0] apb4_paddr,
  input  logic [2:0]  apb4_pprot,
  input  logic [3:0]  apb4_pstrb,
  input  logic        apb4_psel,
  input  logic        apb4_penable,
  input  logic        apb4_pwrite,
  input  logic [31:0] apb4_pwdata,
  output logic [31:0] apb4_prdata,
  output logic        apb4_pready,
  output logic        apb4_pslverr,
  input  logic        pwm_in_i,
  output logic        pwm_irq_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_MAX - 1'b1;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [3:0]        idx;
  logic              wr_stb, rd_stb, ctrl_wr, pscr_wr, stat_rd;
  logic [CTRL_W-1:0] ctrl;
  logic [PSCR_W-1:0] pscr, presc;
  logic [CNT_W-1:0]  cnt, per, high;
  logic [STAT_W-1:0] stat, stat_d;
  logic              en, pwm_sync, pwm_lvl_p0, pwm_lvl_p1, rise, fall, tick;
  logic              meas_act, cap_ev, high_ev, sat_ev;
  meas_state_t       state;
  logic              unused_bits;

  assign unused_bits = ^{apb4_pprot, apb4_pstrb, apb4_paddr[31:6],
                         apb4_paddr[1:0], apb4_pwdata[31:PSCR_W]};

  assign apb4_pready  = 1'b1;
  assign apb4_pslverr = 1'b0;

  assign idx     = apb4_paddr[5:2];
  assign wr_stb  = apb4_psel & apb4_penable & apb4_pwrite;
  assign rd_stb  = apb4_psel & apb4_penable & ~apb4_pwrite;
  assign ctrl_wr = wr_stb && (idx == IDX_CTRL);
  assign pscr_wr = wr_stb && (idx == IDX_PSCR);
  assign stat_rd = rd_stb && (idx == IDX_STAT);

  dffer #(.DATA_W(CTRL_W)) u_ctrl (.clk(apb4_pclk), .rst_n(apb4_presetn), .en(ctrl_wr),
                                   .d(apb4_pwdata[CTRL_W-1:0]), .q(ctrl));
  dffer #(.DATA_W(PSCR_W)) u_pscr (.clk(apb4_pclk), .rst_n(apb4_presetn), .en(pscr_wr),
                                   .d(apb4_pwdata[PSCR_W-1:0]), .q(pscr));

  assign en = ctrl[CTRL_EN];

  // p0: synchronized, polarity-corrected level
  cdc_sync #(.STAGE(SYNC_STAGE), .DATA_WIDTH(1)) u_sync (
    .clk(apb4_pclk), .rst_n(apb4_presetn), .d(pwm_in_i), .q(pwm_sync));

  assign pwm_lvl_p0 = pwm_sync ^ ctrl[CTRL_POL];

  // p1: one-cycle delayed copy for edge detection
  dffer #(.DATA_W(1)) u_dly (.clk(apb4_pclk), .rst_n(apb4_presetn), .en(1'b1),
                             .d(pwm_lvl_p0), .q(pwm_lvl_p1));

  assign rise     = pwm_lvl_p0 & ~pwm_lvl_p1;
  assign fall     = ~pwm_lvl_p0 & pwm_lvl_p1;
  assign tick     = (presc == pscr);
  // A PSCR write restarts the measurement, so it masks events of that cycle.
  assign meas_act = en && !pscr_wr && (state == ST_MEAS);
  assign cap_ev   = meas_act && rise;
  assign high_ev  = meas_act && fall;
  assign sat_ev   = meas_act && !rise && tick && (cnt == CNT_LAST);

  always_ff @(posedge apb4_pclk or negedge apb4_presetn) begin
    if (!apb4_presetn) begin
      state <= ST_IDLE;
      cnt   <= '0;
      presc <= '0;
    end else if (!en) begin
      state <= ST_IDLE;
      cnt   <= '0;
      presc <= '0;
    end else if (pscr_wr) begin
      state <= ST_ARM;
      cnt   <= '0;
      presc <= '0;
    end else begin
      case (state)
        ST_IDLE: state <= ST_ARM;
        ST_ARM: begin
          if (rise) begin
            state <= ST_MEAS;
            cnt   <= CNT_ONE;
            presc <= '0;
          end
        end
        ST_MEAS: begin
          if (rise) begin
            cnt   <= CNT_ONE;
            presc <= '0;
          end else if (tick) begin
            presc <= '0;
            if (cnt == CNT_LAST) begin
              cnt   <= CNT_MAX;
              state <= ST_ARM;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else begin
            presc <= presc + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  dffer #(.DATA_W(CNT_W)) u_per  (.clk(apb4_pclk), .rst_n(apb4_presetn), .en(cap_ev),
                                  .d(cnt), .q(per));
  dffer #(.DATA_W(CNT_W)) u_high (.clk(apb4_pclk), .rst_n(apb4_presetn), .en(high_ev),
                                  .d(cnt), .q(high));

  // Setting events take priority over the clear-on-read of STAT.
  assign stat_d[STAT_CAPIF] = (cap_ev & ctrl[CTRL_CAPIE]) | (stat[STAT_CAPIF] & ~stat_rd);
  assign stat_d[STAT_OVIF]  = (sat_ev & ctrl[CTRL_OVIE])  | (stat[STAT_OVIF]  & ~stat_rd);

  dffer #(.DATA_W(STAT_W)) u_stat (.clk(apb4_pclk), .rst_n(apb4_presetn), .en(1'b1),
                                   .d(stat_d), .q(stat));

  assign pwm_irq_o = stat[STAT_CAPIF] | stat[STAT_OVIF];

  always_comb begin
    apb4_prdata = '0;
    if (rd_stb) begin
      case (idx)
        IDX_CTRL: apb4_prdata[CTRL_W-1:0] = ctrl;
        IDX_PSCR: apb4_prdata[PSCR_W-1:0] = pscr;
        IDX_PER:  apb4_prdata = per;
        IDX_HIGH: apb4_prdata = high;
        IDX_STAT: apb4_prdata[STAT_W-1:0] = stat;
        default:  apb4_prdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_apb4_pwm_cap.sv
// Directed bench for apb4_pwm_cap: APB register access, period/high-time
// capture, prescaling, polarity, saturation, clear-on-read and reset abort.
module tb_apb4_pwm_cap;

  localparam logic [31:0] A_CTRL = 32'h00;
  localparam logic [31:0] A_PSCR = 32'h04;
  localparam logic [31:0] A_PER  = 32'h08;
  localparam logic [31:0] A_HIGH = 32'h0C;
  localparam logic [31:0] A_STAT = 32'h10;
  localparam logic [31:0] A_UNM5 = 32'h14;
  localparam logic [31:0] A_UNMF = 32'h3C;

  logic        clk = 1'b0;
  logic        presetn = 1'b0;
  logic [31:0] paddr = '0;
  logic [2:0]  pprot = '0;
  logic [3:0]  pstrb = 4'hF;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic        pwm_in = 1'b0;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  apb4_pwm_cap #(.SYNC_STAGE(2), .CNT_MAX(32'd64)) dut (
    .apb4_pclk(clk), .apb4_presetn(presetn), .apb4_paddr(paddr), .apb4_pprot(pprot),
    .apb4_pstrb(pstrb), .apb4_psel(psel), .apb4_penable(penable), .apb4_pwrite(pwrite),
    .apb4_pwdata(pwdata), .apb4_prdata(prdata), .apb4_pready(pready),
    .apb4_pslverr(pslverr), .pwm_in_i(pwm_in), .pwm_irq_o(irq));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk); paddr = addr; pwdata = data; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
    @(negedge clk); penable = 1'b1;
    @(negedge clk); psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] addr, output logic [31:0] data);
    @(negedge clk); paddr = addr; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
    @(negedge clk); penable = 1'b1; #1 data = prdata;
    @(negedge clk); psel = 1'b0; penable = 1'b0;
  endtask

  task automatic pwm_drive(input logic level, input int n);
    @(negedge clk); pwm_in = level;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic test_reset;
    logic [31:0] v;
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL rst_irq: got %0b want 0", irq); end
    n_checks++; if (pready !== 1'b1 || pslverr !== 1'b0) begin n_fail++;
      $display("FAIL rst_resp: pready %0b pslverr %0b want 1/0", pready, pslverr); end
    @(negedge clk); presetn = 1'b1;
    n_checks++; if (prdata !== 32'd0) begin n_fail++; $display("FAIL idle_prdata: got %h want 0", prdata); end
    apb_read(A_CTRL, v);
    n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL rst_ctrl: got %h want 0", v); end
    apb_read(A_PSCR, v);
    n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL rst_pscr: got %h want 0", v); end
    apb_read(A_PER, v);
    n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL rst_per: got %h want 0", v); end
    apb_read(A_HIGH, v);
    n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL rst_high: got %h want 0", v); end
    apb_read(A_STAT, v);
    n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL rst_stat: got %h want 0", v); end
  endtask

  task automatic test_regs;
    logic [31:0] v;
    apb_write(A_CTRL, 32'hFFFF_FFFF);
    apb_read(A_CTRL, v);
    n_checks++; if (v !== 32'h0000_000F) begin n_fail++; $display("FAIL ctrl_rw: got %h want 0000000f", v); end
    apb_write(A_PSCR, 32'hFFFF_FFFF);
    apb_read(A_PSCR, v);
    n_checks++; if (v !== 32'h0000_FFFF) begin n_fail++; $display("FAIL pscr_rw: got %h want 0000ffff", v); end
    apb_write(A_PER, 32'h1234_5678);
    apb_write(A_STAT, 32'h3);
    apb_read(A_PER, v);
    n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL per_ro: got %h want 0", v); end
    apb_read(A_STAT, v);
    n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL stat_ro: got %h want 0", v); end
    apb_read(A_UNM5, v);
    n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL unmapped5: got %h want 0", v); end
    apb_read(A_UNMF, v);
    n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL unmapped15: got %h want 0", v); end
    apb_write(A_CTRL, 32'h0);
    apb_write(A_PSCR, 32'h0);
  endtask

  task automatic test_basic;
    logic [31:0] v;
    apb_write(A_CTRL, 32'h3);
    repeat (3) begin pwm_drive(1'b1, 3); pwm_drive(1'b0, 7); end
    apb_read(A_PER, v);
    n_checks++; if (v !== 32'd10) begin n_fail++; $display("FAIL basic_per: got %0d want 10", v); end
    apb_read(A_HIGH, v);
    n_checks++; if (v !== 32'd3) begin n_fail++; $display("FAIL basic_high: got %0d want 3", v); end
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL basic_irq: got %0b want 1", irq); end
    apb_read(A_STAT, v);
    n_checks++; if (v !== 32'd1) begin n_fail++; $display("FAIL basic_stat: got %h want 1", v); end
    #1;
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL basic_irq_clr: got %0b want 0", irq); end
    apb_read(A_STAT, v);
    n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL basic_stat_clr: got %h want 0", v); end
  endtask

  task automatic test_prescale;
    logic [31:0] v;
    apb_write(A_PSCR, 32'd1);
    repeat (3) begin pwm_drive(1'b1, 3); pwm_drive(1'b0, 7); end
    apb_read(A_PER, v);
    n_checks++; if (v !== 32'd5) begin n_fail++; $display("FAIL pscr_per: got %0d want 5", v); end
    apb_read(A_HIGH, v);
    n_checks++; if (v !== 32'd2) begin n_fail++; $display("FAIL pscr_high: got %0d want 2", v); end
    apb_read(A_STAT, v);
    n_checks++; if (v !== 32'd1) begin n_fail++; $display("FAIL pscr_stat: got %h want 1", v); end
  endtask

  task automatic test_polarity;
    logic [31:0] v;
    apb_write(A_CTRL, 32'h8);
    apb_write(A_PSCR, 32'd0);
    apb_write(A_CTRL, 32'hB);
    repeat (4) begin pwm_drive(1'b1, 7); pwm_drive(1'b0, 3); end
    apb_read(A_PER, v);
    n_checks++; if (v !== 32'd10) begin n_fail++; $display("FAIL pol_per: got %0d want 10", v); end
    apb_read(A_HIGH, v);
    n_checks++; if (v !== 32'd3) begin n_fail++; $display("FAIL pol_high: got %0d want 3", v); end
    apb_read(A_STAT, v);
    n_checks++; if (v !== 32'd1) begin n_fail++; $display("FAIL pol_stat: got %h want 1", v); end
  endtask

  task automatic test_overflow;
    logic [31:0] v;
    apb_write(A_CTRL, 32'h0);
    apb_read(A_STAT, v);
    apb_write(A_CTRL, 32'h7);
    pwm_drive(1'b1, 4);
    pwm_drive(1'b0, 74);
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL ovf_irq: got %0b want 1", irq); end
    apb_read(A_STAT, v);
    n_checks++; if (v !== 32'd2) begin n_fail++; $display("FAIL ovf_stat: got %h want 2", v); end
    apb_read(A_HIGH, v);
    n_checks++; if (v !== 32'd4) begin n_fail++; $display("FAIL ovf_high: got %0d want 4", v); end
    fork
      begin
        pwm_drive(1'b1, 2); pwm_drive(1'b0, 6);
        pwm_drive(1'b1, 2); pwm_drive(1'b0, 6);
      end
      begin
        logic [31:0] pv;
        repeat (7) @(negedge clk);
        apb_read(A_PER, pv);
        n_checks++; if (pv !== 32'd10) begin n_fail++; $display("FAIL ovf_no_cap: got %0d want 10", pv); end
      end
    join
    apb_read(A_PER, v);
    n_checks++; if (v !== 32'd8) begin n_fail++; $display("FAIL ovf_recap: got %0d want 8", v); end
  endtask

  task automatic test_same_cycle;
    logic [31:0] v;
    apb_write(A_CTRL, 32'h0);
    apb_read(A_STAT, v);
    apb_write(A_PSCR, 32'd0);
    apb_write(A_CTRL, 32'h3);
    fork
      begin
        repeat (3) begin pwm_drive(1'b1, 3); pwm_drive(1'b0, 7); end
      end
      begin
        logic [31:0] sv;
        repeat (14) @(negedge clk);
        apb_read(A_STAT, sv);
        n_checks++; if (sv !== 32'd1) begin n_fail++; $display("FAIL sc_pre_stat: got %h want 1", sv); end
        repeat (4) @(negedge clk);
        apb_read(A_STAT, sv);
        n_checks++; if (sv !== 32'd0) begin n_fail++; $display("FAIL sc_read_val: got %h want 0", sv); end
      end
    join
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL sc_irq: got %0b want 1", irq); end
    apb_read(A_STAT, v);
    n_checks++; if (v !== 32'd1) begin n_fail++; $display("FAIL sc_capif_kept: got %h want 1", v); end
    apb_write(A_CTRL, 32'h0);
    repeat (2) begin pwm_drive(1'b1, 3); pwm_drive(1'b0, 7); end
    apb_read(A_PER, v);
    n_checks++; if (v !== 32'd10) begin n_fail++; $display("FAIL dis_per: got %0d want 10", v); end
    apb_read(A_STAT, v);
    n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL dis_stat: got %h want 0", v); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL dis_irq: got %0b want 0", irq); end
  endtask

  task automatic test_reset_abort;
    logic [31:0] v;
    apb_write(A_PSCR, 32'd0);
    apb_write(A_CTRL, 32'h3);
    pwm_drive(1'b1, 3); pwm_drive(1'b0, 7);
    pwm_drive(1'b1, 3); pwm_drive(1'b0, 3);
    apb_read(A_PER, v);
    n_checks++; if (v !== 32'd10) begin n_fail++; $display("FAIL ra_pre_per: got %0d want 10", v); end
    @(negedge clk); #2 presetn = 1'b0;
    #1;
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL ra_irq: got %0b want 0", irq); end
    repeat (2) @(negedge clk);
    presetn = 1'b1;
    apb_read(A_CTRL, v);
    n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL ra_ctrl: got %h want 0", v); end
    apb_read(A_PER, v);
    n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL ra_per: got %h want 0", v); end
    apb_read(A_HIGH, v);
    n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL ra_high: got %h want 0", v); end
    apb_read(A_STAT, v);
    n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL ra_stat: got %h want 0", v); end
    apb_write(A_CTRL, 32'h3);
    fork
      begin
        repeat (2) begin pwm_drive(1'b1, 3); pwm_drive(1'b0, 7); end
      end
      begin
        logic [31:0] pv;
        repeat (8) @(negedge clk);
        apb_read(A_PER, pv);
        n_checks++; if (pv !== 32'd0) begin n_fail++; $display("FAIL ra_arm_only: got %0d want 0", pv); end
      end
    join
    apb_read(A_PER, v);
    n_checks++; if (v !== 32'd10) begin n_fail++; $display("FAIL ra_per_cap: got %0d want 10", v); end
    apb_read(A_HIGH, v);
    n_checks++; if (v !== 32'd3) begin n_fail++; $display("FAIL ra_high_cap: got %0d want 3", v); end
  endtask

  initial begin
    test_reset();
    test_regs();
    test_basic();
    test_prescale();
    test_polarity();
    test_overflow();
    test_same_cycle();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
